// File: rtl/snake_dir_ctrl.sv
// Snake direction/timing front end: syncs and debounces the four
// active-low buttons, commits a heading and emits the step pulse.
// Ports: clk, reset (async, active low), btn1..btn4 (right, up, down,
// left, active low), step (1-cycle pulse), dir (00 R, 01 U, 10 D,
// 11 L), moving (high after the first accepted press).
module snake_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_CYCLES     = 8000000,
  parameter int DB_W            = 18,
  parameter int ST_W            = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  output logic       step,
  output logic [1:0] dir,
  output logic       moving
);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST =
    ST_W'(STEP_CYCLES - 1);

  logic [3:0]      pins;
  logic [3:0]      s1;
  logic [3:0]      s2;
  logic [3:0]      lvl;
  logic [3:0]      press;
  logic [DB_W-1:0] cnt [4];

  logic [ST_W-1:0] scnt;
  logic [1:0]      pending;
  logic [1:0]      code;
  logic            hit;
  logic            take;

  assign pins = {btn4, btn3, btn2, btn1};

  // Sync + debounce; press fires on the edge the level falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '1;
      s2    <= '1;
      lvl   <= '1;
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1    <= pins;
      s2    <= s1;
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]   <= '0;
          lvl[i]   <= ~lvl[i];
          press[i] <= lvl[i];
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Fixed priority: btn1 > btn2 > btn3 > btn4.
  always_comb begin
    hit  = |press;
    code = 2'd0;
    if (press[0]) begin
      code = 2'd0;
    end else if (press[1]) begin
      code = 2'd1;
    end else if (press[2]) begin
      code = 2'd2;
    end else if (press[3]) begin
      code = 2'd3;
    end
  end

  // Opposite headings are bitwise complements.
  assign take = hit && (code != ~dir);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step    <= 1'b0;
      dir     <= 2'd0;
      pending <= 2'd0;
      moving  <= 1'b0;
      scnt    <= '0;
    end else if (!moving) begin
      step <= 1'b0;
      scnt <= '0;
      if (hit) begin
        moving  <= 1'b1;
        dir     <= code;
        pending <= code;
      end
    end else begin
      if (scnt == ST_LAST) begin
        step <= 1'b1;
        scnt <= '0;
      end else begin
        step <= 1'b0;
        scnt <= scnt + ST_W'(1);
      end
      // Commit on the edge closing a step cycle.
      if (step) begin
        dir <= take ? code : pending;
      end
      if (take) begin
        pending <= code;
      end
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Randomised + directed bench for snake_dir_ctrl against an
// event-level reference model.
module tb_snake_dir_ctrl;

  localparam int D = 4;
  localparam int S = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn1;
  logic       btn2;
  logic       btn3;
  logic       btn4;
  logic       step;
  logic [1:0] dir;
  logic       moving;

  int vec = 0;
  int errs = 0;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .STEP_CYCLES(S),
    .DB_W(4),
    .ST_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn1(btn1),
    .btn2(btn2),
    .btn3(btn3),
    .btn4(btn4),
    .step(step),
    .dir(dir),
    .moving(moving)
  );

  always #5 clk = ~clk;

  // Reference model state. n counts edges since reset release.
  int         n;
  logic [3:0] hist[$];
  logic [3:0] m_lvl;
  int         since[4];
  logic [3:0] m_ev;
  logic       m_moving;
  logic       m_step;
  logic [1:0] m_dir;
  logic [1:0] m_pend;
  int         t_move;

  task automatic model_reset();
    n = 0;
    hist.delete();
    m_lvl = 4'hF;
    for (int i = 0; i < 4; i++) since[i] = 0;
    m_ev = 4'h0;
    m_moving = 1'b0;
    m_step = 1'b0;
    m_dir = 2'd0;
    m_pend = 2'd0;
    t_move = 0;
  endtask

  // Synchronised value seen at edge e is the pin two edges earlier.
  function automatic logic syncv(int i, int e);
    if (e - 2 < 1) return 1'b1;
    return hist[e-3][i];
  endfunction

  task automatic model_edge(input logic [3:0] p);
    logic       hit;
    logic [1:0] code;
    logic       take;
    logic       prev_step;
    logic [3:0] nev;
    logic       all;
    n++;
    hist.push_back(p);
    prev_step = m_step;
    hit = |m_ev;
    code = 2'd0;
    for (int i = 3; i >= 0; i--) if (m_ev[i]) code = 2'(i);
    if (!m_moving) begin
      m_step = 1'b0;
      if (hit) begin
        m_moving = 1'b1;
        t_move = n;
        m_dir = code;
        m_pend = code;
      end
    end else begin
      take = hit && (code != 2'd3 - m_dir);
      if (prev_step) m_dir = take ? code : m_pend;
      if (take) m_pend = code;
      m_step = ((n - t_move) % S) == 0;
    end
    // Level flips once D consecutive synced samples disagree.
    nev = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (n - since[i] >= D) begin
        all = 1'b1;
        for (int k = n - D + 1; k <= n; k++)
          if (syncv(i, k) == m_lvl[i]) all = 1'b0;
        if (all) begin
          nev[i] = m_lvl[i];
          m_lvl[i] = ~m_lvl[i];
          since[i] = n;
        end
      end
    end
    m_ev = nev;
  endtask

  task automatic chk(input string nm, input logic [1:0] got,
                     input logic [1:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %0d want %0d edge %0d",
               nm, got, want, n);
    end
  endtask

  task automatic cycle(input logic [3:0] p);
    btn1 = p[0];
    btn2 = p[1];
    btn3 = p[2];
    btn4 = p[3];
    @(posedge clk);
    model_edge(p);
    @(negedge clk);
    chk("step", {1'b0, step}, {1'b0, m_step});
    chk("dir", dir, m_dir);
    chk("moving", {1'b0, moving}, {1'b0, m_moving});
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_step", {1'b0, step}, 2'd0);
    chk("rst_dir", dir, 2'd0);
    chk("rst_moving", {1'b0, moving}, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic hold(input logic [3:0] p, input int c);
    for (int i = 0; i < c; i++) cycle(p);
  endtask

  logic [3:0] pv;
  int         rem[4];

  initial begin
    reset = 1'b0;
    btn1 = 1'b1;
    btn2 = 1'b1;
    btn3 = 1'b1;
    btn4 = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    apply_reset();

    // Idle: nothing happens.
    hold(4'hF, 50);
    chk("idle_moving", {1'b0, moving}, 2'd0);
    chk("idle_dir", dir, 2'd0);

    // btn2 held from the first cycle.
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      cycle(4'b1101);
      if (i == 6) chk("up_mv6", {1'b0, moving}, 2'd0);
      if (i == 7) chk("up_mv7", {1'b0, moving}, 2'd1);
      if (i == 7) chk("up_dir7", dir, 2'd1);
      if (i == 16) chk("up_st16", {1'b0, step}, 2'd0);
      if (i == 17 || i == 27 || i == 37)
        chk("up_step", {1'b0, step}, 2'd1);
      if (i == 18 || i == 28 || i == 38)
        chk("up_1wide", {1'b0, step}, 2'd0);
    end

    // Short glitch, then real press of btn1.
    apply_reset();
    hold(4'b1110, 3);
    hold(4'hF, 10);
    chk("glitch_mv", {1'b0, moving}, 2'd0);
    hold(4'b1110, 6);
    hold(4'hF, 4);
    chk("r_moving", {1'b0, moving}, 2'd1);
    chk("r_dir", dir, 2'd0);

    // Reversal to left is dropped, then down commits.
    hold(4'b0111, 6);
    hold(4'hF, 35);
    chk("rev_dir", dir, 2'd0);
    hold(4'b1011, 6);
    hold(4'hF, 14);
    chk("down_dir", dir, 2'd2);

    // btn1 and btn3 together while heading up: btn1 wins.
    apply_reset();
    hold(4'b1101, 6);
    hold(4'hF, 3);
    hold(4'b1010, 6);
    hold(4'hF, 14);
    chk("prio_dir", dir, 2'd0);

    // Reset mid-interval while heading left.
    apply_reset();
    hold(4'b0111, 6);
    hold(4'hF, 16);
    chk("left_dir", dir, 2'd3);
    apply_reset();
    hold(4'hF, 20);
    chk("post_mv", {1'b0, moving}, 2'd0);
    for (int j = 1; j <= 20; j++) begin
      cycle(j <= 6 ? 4'b1110 : 4'hF);
      if (j == 16) chk("post_st16", {1'b0, step}, 2'd0);
      if (j == 17) chk("post_st17", {1'b0, step}, 2'd1);
    end

    // Random button activity with occasional resets.
    pv = 4'hF;
    for (int i = 0; i < 4; i++) rem[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          if ($urandom_range(0, 2) == 0) begin
            pv[i] = 1'b0;
            rem[i] = int'($urandom_range(1, 8));
          end else begin
            pv[i] = 1'b1;
            rem[i] = int'($urandom_range(1, 25));
          end
        end
      end
      cycle(pv);
      if ($urandom_range(0, 399) == 0) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Upstream input/timing stage for the snake game logic; sits between the board buttons and the snake body-update logic.
- Synchronises and debounces the four active-low direction buttons and converts presses into a committed 2-bit heading.
- Rejects 180° reversals.
- Generates the single-cycle step pulse on which the game logic advances the head and tail.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a button level change is accepted (10 ms at 25 MHz).
- STEP_CYCLES, 8000000, clock cycles between step pulses while moving.
- DB_W, 18, debounce counter width; must hold DEBOUNCE_CYCLES.
- ST_W, 23, step counter width; must hold STEP_CYCLES-1.

Ports:
- clk  in  1  PLL pixel clock (25 MHz); sole clock.
- reset  in  1  asynchronous, active-low reset.
- btn1  in  1  right button, active low, asynchronous to clk.
- btn2  in  1  up button, active low.
- btn3  in  1  down button, active low.
- btn4  in  1  left button, active low.
- step  out  1  one-cycle pulse; the game advances one cell.
- dir  out  2  committed heading: 00 right, 01 up, 10 down, 11 left.
- moving  out  1  high once the first valid press has been accepted.

Behaviour:

Reset (async, reset=0):
- Sync flops and debounced levels = 1 (released).
- Debounce counters = 0; step counter = 0.
- step = 0, dir = 00, pending = 00, moving = 0.
- Reset asserted mid-operation clears everything immediately, with no pulse on release.

Synchronisation:
- Each button passes through a 2-flop synchroniser; no logic reads the raw pins.

Debounce (per button, independent):
- Counter increments each cycle the synchronised level differs from the debounced level.
- Counter clears to 0 on any agreeing cycle.
- On the DEBOUNCE_CYCLES-th consecutive disagreeing cycle, the debounced level toggles and the counter clears.
- Press event = debounced 1→0 transition, one cycle wide.
- Release produces no event.
- A glitch shorter than DEBOUNCE_CYCLES produces nothing.

Press priority:
- If several press events fire in the same cycle, only one is taken: btn1 > btn2 > btn3 > btn4.

Acceptance:
- moving=0: any press sets dir, pending and moving on the next edge. No reversal check applies; the step counter starts from 0.
- moving=1: a press loads pending unless its code is the opposite of the committed dir (right↔left, up↔down). Opposite presses are dropped silently.
- A press matching dir, or replacing an earlier pending, is allowed; last press before a step wins.

Step timer:
- Counts only while moving=1.
- When counter = STEP_CYCLES-1: step=1 for that one cycle and the counter wraps to 0.
- The first step occurs exactly STEP_CYCLES cycles after moving rises.

Commit:
- On the edge that ends a step cycle, dir <= pending.
- dir is therefore stable between steps. The consumer samples dir in the step cycle, which shows the heading used for the move just ending (old dir).
- Simultaneous press and step cycle: the press is checked against the current dir. If accepted, dir and pending both take the new value at that edge.

Outputs:
- All outputs are registered; no combinational path from btn pins.
- Latency from pin press (stable low) to press event = 2 + DEBOUNCE_CYCLES cycles.

Widths:
- Counters compare with equality only.
- Overflow is impossible when the widths meet the parameter constraints.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=10):
- Reset, then idle 50 cycles with all buttons high → step never pulses, dir=00, moving=0.
- Hold btn2 low from cycle 0 → moving rises at cycle 7 (2+4 cycles to the event, plus the registering edge), dir=01. step pulses at cycles 17, 27, 37 and is one cycle wide each time.
- Pulse btn1 low for 3 cycles, then high → no press event, moving stays 0. Then hold it 6 cycles → dir=00 and moving=1.
- Heading dir=00, then press btn4 (left) → pending unchanged, dir stays 00 across the next 3 steps. Then press btn3 → dir becomes 10 at the first step after acceptance, not before.
- Press events for btn3 and btn1 in the same cycle while dir=01 → btn1 wins, and dir=00 after the next step.
- Assert reset for 1 cycle midway through a step interval with dir=11 → step=0, dir=00, moving=0 immediately. No step until a new press plus 10 cycles.
